// File: rtl/writeback_arb_if.sv
// Bundles the producer request channels and the register-file write port of writeback_arb.
// The slave modport is the arbiter's view; the master modport drives producers and the register file.
interface writeback_arb_if #(
   parameter int NCH   = 2,
   parameter int DW    = 16,
   parameter int AW    = 4,
   parameter int DEPTH = 4
);
   localparam int LW = $clog2(DEPTH + 1);

   logic [NCH-1:0]    req;
   logic [NCH-1:0]    ack;
   logic [NCH*AW-1:0] rd;
   logic [NCH*DW-1:0] result;
   logic              write_en;
   logic [AW-1:0]     write_addr;
   logic [DW-1:0]     write_data;
   logic              reg_ack;
   logic [LW-1:0]     fifo_level;
   logic              busy;

   modport master (
      output req, rd, result, reg_ack,
      input  ack, write_en, write_addr, write_data, fifo_level, busy
   );

   modport slave (
      input  req, rd, result, reg_ack,
      output ack, write_en, write_addr, write_data, fifo_level, busy
   );
endinterface

// File: rtl/writeback_arb.sv
// Round-robin arbiter collecting register writes from NCH producers into a small FIFO,
// drained one write at a time through a request/acknowledge register-file port.
module writeback_arb #(
   parameter int NCH        = 2,
   parameter int DW         = 16,
   parameter int AW         = 4,
   parameter int DEPTH      = 4,
   parameter bit DISCARD_R0 = 1'b1
) (
   input logic           clk,
   input logic           rst_n,
   writeback_arb_if.slave bus
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int LW = $clog2(DEPTH + 1);
   localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

   typedef enum logic {
      IDLE,
      WAIT_ACK
   } state_t;

   state_t            state_q, state_d;
   logic [AW+DW-1:0]  mem [DEPTH];
   logic [PW-1:0]     wptr, rptr;
   logic [LW-1:0]     level;
   logic [NCH-1:0]    ack_q;
   logic [CW-1:0]     last_q;
   logic              we_q, we_d;
   logic [AW-1:0]     addr_q, addr_d;
   logic [DW-1:0]     data_q, data_d;

   logic [NCH-1:0]    elig;
   logic              gnt_valid;
   logic [CW-1:0]     gnt_idx;
   int unsigned       cand;
   logic [AW-1:0]     gnt_rd;
   logic [DW-1:0]     gnt_data;
   logic              push, pop;

   // A channel whose ack is on this cycle is finishing, so it cannot be granted again yet.
   always_comb begin
      elig      = bus.req & ~ack_q;
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      cand      = 0;
      if (level < LW'(DEPTH)) begin
         for (int unsigned k = 1; k <= NCH; k++) begin
            cand = (32'(last_q) + k) % NCH;
            if (!gnt_valid && elig[CW'(cand)]) begin
               gnt_valid = 1'b1;
               gnt_idx   = CW'(cand);
            end
         end
      end
   end

   assign gnt_rd   = bus.rd[gnt_idx*AW +: AW];
   assign gnt_data = bus.result[gnt_idx*DW +: DW];
   assign push     = gnt_valid && !(DISCARD_R0 && (gnt_rd == '0));

   // The head entry stays counted in level until reg_ack retires it.
   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      addr_d  = addr_q;
      data_d  = data_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            if (level != '0) begin
               we_d             = 1'b1;
               {addr_d, data_d} = mem[rptr];
               state_d          = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            if (bus.reg_ack) begin
               we_d    = 1'b0;
               pop     = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         ack_q   <= '0;
         last_q  <= CW'(NCH - 1);
         wptr    <= '0;
         rptr    <= '0;
         level   <= '0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         ack_q   <= '0;
         if (gnt_valid) begin
            ack_q[gnt_idx] <= 1'b1;
            last_q         <= gnt_idx;
         end
         if (push) wptr <= wptr + PW'(1);
         if (pop)  rptr <= rptr + PW'(1);
         level <= level + LW'(push) - LW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= {gnt_rd, gnt_data};
   end

   assign bus.ack        = ack_q;
   assign bus.write_en   = we_q;
   assign bus.write_addr = addr_q;
   assign bus.write_data = data_q;
   assign bus.fifo_level = level;
   assign bus.busy       = (level != '0) || we_q;
endmodule

// File: tb/tb_writeback_arb.sv
// Bench for writeback_arb: hand-derived vector table, directed full/reset sequences,
// and random traffic checked every cycle against a queue-based reference model.
module tb_writeback_arb;
   localparam int NCH   = 2;
   localparam int DW    = 16;
   localparam int AW    = 4;
   localparam int DEPTH = 4;
   localparam int CW    = 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   writeback_arb_if #(.NCH(NCH), .DW(DW), .AW(AW), .DEPTH(DEPTH)) bus ();

   writeback_arb #(
      .NCH(NCH), .DW(DW), .AW(AW), .DEPTH(DEPTH), .DISCARD_R0(1'b1)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   int total = 0;
   int bad   = 0;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, act, exp, $time);
      end
   endfunction

   // Reference model: pending writes as a queue of {addr,data}, one outstanding write flag.
   logic [NCH-1:0]   ack_m;
   int               last_m;
   int               lvl_m, lvl_prev;
   logic             we_m;
   logic [AW-1:0]    addr_m;
   logic [DW-1:0]    data_m;
   logic [AW+DW-1:0] q[$];
   logic [NCH-1:0]   m_elig;
   logic             m_gv;
   int               m_g;
   logic [AW-1:0]    m_rd;

   always @(posedge clk) begin
      if (!rst_n) begin
         ack_m  = '0;
         last_m = NCH - 1;
         lvl_m  = 0;
         we_m   = 1'b0;
         addr_m = '0;
         data_m = '0;
         q.delete();
      end else begin
         lvl_prev = lvl_m;
         m_elig   = bus.req & ~ack_m;
         m_gv     = 1'b0;
         m_g      = 0;
         if (lvl_prev < DEPTH)
            for (int k = 1; k <= NCH; k++)
               if (!m_gv && m_elig[CW'((last_m + k) % NCH)]) begin
                  m_gv = 1'b1;
                  m_g  = (last_m + k) % NCH;
               end
         ack_m = '0;
         if (m_gv) begin
            ack_m[CW'(m_g)] = 1'b1;
            last_m = m_g;
            m_rd = bus.rd[m_g*AW +: AW];
            if (m_rd != '0) begin
               q.push_back({m_rd, bus.result[m_g*DW +: DW]});
               lvl_m++;
            end
         end
         if (we_m) begin
            if (bus.reg_ack) begin
               we_m = 1'b0;
               q.delete(0);
               lvl_m--;
            end
         end else if (lvl_prev != 0) begin
            we_m             = 1'b1;
            {addr_m, data_m} = q[0];
         end
      end
      #1;
      check("mon_ack",   32'(bus.ack),        32'(ack_m));
      check("mon_we",    32'(bus.write_en),   32'(we_m));
      check("mon_addr",  32'(bus.write_addr), 32'(addr_m));
      check("mon_data",  32'(bus.write_data), 32'(data_m));
      check("mon_level", 32'(bus.fifo_level), 32'(lvl_m));
      check("mon_busy",  32'(bus.busy),       32'(lvl_m != 0));
   end

   typedef struct {
      logic [1:0]  req;
      logic [3:0]  rd0;
      logic [15:0] d0;
      logic [3:0]  rd1;
      logic [15:0] d1;
      logic        rack;
      logic [1:0]  ack;
      logic        we;
      logic [3:0]  addr;
      logic [15:0] data;
      logic [2:0]  lvl;
   } vec_t;

   function automatic vec_t mkv(input logic [1:0] req, input logic [3:0] rd0, input logic [15:0] d0,
                                input logic [3:0] rd1, input logic [15:0] d1, input logic rack,
                                input logic [1:0] ack, input logic we, input logic [3:0] addr,
                                input logic [15:0] data, input logic [2:0] lvl);
      vec_t v;
      v.req = req; v.rd0 = rd0; v.d0 = d0; v.rd1 = rd1; v.d1 = d1; v.rack = rack;
      v.ack = ack; v.we = we; v.addr = addr; v.data = data; v.lvl = lvl;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic drive(input logic [1:0] r, input logic [3:0] a0, input logic [15:0] d0,
                        input logic [3:0] a1, input logic [15:0] d1, input logic ra);
      bus.req     = r;
      bus.rd      = {a1, a0};
      bus.result  = {d1, d0};
      bus.reg_ack = ra;
   endtask

   task automatic do_reset();
      drive(2'b00, 4'd0, 16'h0, 4'd0, 16'h0, 1'b0);
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic wait_ack(input int ch, input int bound, output bit got);
      got = 1'b0;
      for (int i = 0; i < bound && !got; i++) begin
         tick();
         if (bus.ack[CW'(ch)]) got = 1'b1;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got=running expected=finished");
      $fatal(1, "watchdog");
   end

   vec_t vec[16];
   bit   got;

   initial begin
      // single write, R0 discard, then both channels contending with reg_ack held high
      vec[0]  = mkv(2'b01, 4'd5, 16'hBEEF, 4'd0, 16'h0000, 1'b0, 2'b01, 1'b0, 4'd0, 16'h0000, 3'd1);
      vec[1]  = mkv(2'b00, 4'd5, 16'hBEEF, 4'd0, 16'h0000, 1'b0, 2'b00, 1'b1, 4'd5, 16'hBEEF, 3'd1);
      vec[2]  = mkv(2'b00, 4'd5, 16'hBEEF, 4'd0, 16'h0000, 1'b1, 2'b00, 1'b0, 4'd5, 16'hBEEF, 3'd0);
      vec[3]  = mkv(2'b00, 4'd5, 16'hBEEF, 4'd0, 16'h0000, 1'b0, 2'b00, 1'b0, 4'd5, 16'hBEEF, 3'd0);
      vec[4]  = mkv(2'b01, 4'd0, 16'h1234, 4'd0, 16'h0000, 1'b0, 2'b01, 1'b0, 4'd5, 16'hBEEF, 3'd0);
      vec[5]  = mkv(2'b00, 4'd0, 16'h1234, 4'd0, 16'h0000, 1'b0, 2'b00, 1'b0, 4'd5, 16'hBEEF, 3'd0);
      vec[6]  = mkv(2'b00, 4'd0, 16'h1234, 4'd0, 16'h0000, 1'b0, 2'b00, 1'b0, 4'd5, 16'hBEEF, 3'd0);
      vec[7]  = mkv(2'b11, 4'd1, 16'h1111, 4'd2, 16'h2222, 1'b1, 2'b10, 1'b0, 4'd5, 16'hBEEF, 3'd1);
      vec[8]  = mkv(2'b11, 4'd1, 16'h1111, 4'd2, 16'h2222, 1'b1, 2'b01, 1'b1, 4'd2, 16'h2222, 3'd2);
      vec[9]  = mkv(2'b11, 4'd1, 16'h1111, 4'd2, 16'h2222, 1'b1, 2'b10, 1'b0, 4'd2, 16'h2222, 3'd2);
      vec[10] = mkv(2'b11, 4'd1, 16'h1111, 4'd2, 16'h2222, 1'b1, 2'b01, 1'b1, 4'd1, 16'h1111, 3'd3);
      vec[11] = mkv(2'b11, 4'd1, 16'h1111, 4'd2, 16'h2222, 1'b1, 2'b10, 1'b0, 4'd1, 16'h1111, 3'd3);
      vec[12] = mkv(2'b11, 4'd1, 16'h1111, 4'd2, 16'h2222, 1'b1, 2'b01, 1'b1, 4'd2, 16'h2222, 3'd4);
      vec[13] = mkv(2'b11, 4'd1, 16'h1111, 4'd2, 16'h2222, 1'b1, 2'b00, 1'b0, 4'd2, 16'h2222, 3'd3);
      vec[14] = mkv(2'b11, 4'd1, 16'h1111, 4'd2, 16'h2222, 1'b1, 2'b10, 1'b1, 4'd1, 16'h1111, 3'd4);
      vec[15] = mkv(2'b11, 4'd1, 16'h1111, 4'd2, 16'h2222, 1'b1, 2'b00, 1'b0, 4'd1, 16'h1111, 3'd3);

      do_reset();
      check("reset_we",    32'(bus.write_en),   32'd0);
      check("reset_level", 32'(bus.fifo_level), 32'd0);
      check("reset_busy",  32'(bus.busy),       32'd0);
      check("reset_addr",  32'(bus.write_addr), 32'd0);

      for (int i = 0; i < 16; i++) begin
         drive(vec[i].req, vec[i].rd0, vec[i].d0, vec[i].rd1, vec[i].d1, vec[i].rack);
         tick();
         check($sformatf("vec%0d_ack", i),   32'(bus.ack),        32'(vec[i].ack));
         check($sformatf("vec%0d_we", i),    32'(bus.write_en),   32'(vec[i].we));
         check($sformatf("vec%0d_addr", i),  32'(bus.write_addr), 32'(vec[i].addr));
         check($sformatf("vec%0d_data", i),  32'(bus.write_data), 32'(vec[i].data));
         check($sformatf("vec%0d_level", i), 32'(bus.fifo_level), 32'(vec[i].lvl));
      end

      // buffer full: four transfers accepted, fifth held until one write retires
      do_reset();
      for (int t = 0; t < 4; t++) begin
         drive(2'b01, 4'(t + 1), 16'(16'hA000 + t), 4'd0, 16'h0, 1'b0);
         wait_ack(0, 4, got);
         check("full_ack", 32'(got), 32'd1);
      end
      check("full_level4", 32'(bus.fifo_level), 32'd4);
      drive(2'b01, 4'd5, 16'hA004, 4'd0, 16'h0, 1'b0);
      wait_ack(0, 8, got);
      check("full_hold_noack", 32'(got), 32'd0);
      check("full_hold_level", 32'(bus.fifo_level), 32'd4);
      check("full_we",         32'(bus.write_en),   32'd1);
      check("full_head_addr",  32'(bus.write_addr), 32'd1);
      bus.reg_ack = 1'b1;
      tick();
      bus.reg_ack = 1'b0;
      check("full_pop_level", 32'(bus.fifo_level), 32'd3);
      check("full_pop_noack", 32'(bus.ack),        32'd0);
      wait_ack(0, 4, got);
      check("full_fifth_ack",   32'(got),            32'd1);
      check("full_fifth_level", 32'(bus.fifo_level), 32'd4);

      // reset while three entries are buffered and a write is outstanding
      do_reset();
      for (int t = 0; t < 3; t++) begin
         drive(2'b10, 4'd0, 16'h0, 4'(t + 7), 16'(16'hC000 + t), 1'b0);
         wait_ack(1, 4, got);
         check("mid_ack", 32'(got), 32'd1);
      end
      drive(2'b00, 4'd0, 16'h0, 4'd0, 16'h0, 1'b0);
      got = 1'b0;
      for (int i = 0; i < 4 && !got; i++) begin
         tick();
         got = bus.write_en;
      end
      check("mid_we_up",  32'(got),            32'd1);
      check("mid_level3", 32'(bus.fifo_level), 32'd3);
      check("mid_addr",   32'(bus.write_addr), 32'd7);
      rst_n = 1'b0;
      #1;
      check("mid_rst_we",    32'(bus.write_en),   32'd0);
      check("mid_rst_level", 32'(bus.fifo_level), 32'd0);
      check("mid_rst_busy",  32'(bus.busy),       32'd0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("mid_quiet_we",  32'(bus.write_en), 32'd0);
         check("mid_quiet_ack", 32'(bus.ack),      32'd0);
      end

      // random traffic; the monitor compares every cycle
      do_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int i = 0; i < NCH; i++) begin
            if (bus.ack[CW'(i)] || !bus.req[CW'(i)]) begin
               bus.req[CW'(i)]          = ($urandom_range(0, 1) == 1);
               bus.rd[i*AW +: AW]       = AW'($urandom_range(0, 15));
               bus.result[i*DW +: DW]   = DW'($urandom);
            end
         end
         bus.reg_ack = ($urandom_range(0, 2) != 0);
         tick();
      end
      bus.req     = '0;
      bus.reg_ack = 1'b1;
      repeat (20) tick();
      check("drain_level", 32'(bus.fifo_level), 32'd0);
      check("drain_we",    32'(bus.write_en),   32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
